mux8_scan_ctrl: RTL
===================

# mux8_scan_ctrl

Sequencer that sits directly upstream of the 8-to-1 multiplexer and closes the loop on its output. It accepts an 8-bit word over a valid/ready handshake and presents it on the mux data inputs. It then steps the select lines through all eight channels with the enable asserted and captures the mux output bit for each channel. When the scan finishes it reports the reassembled word and flags any channel whose captured bit differs from the bit driven.

## Interface
- LSB_FIRST, 1: 1 = scan order sel 0→7; 0 = scan order sel 7→0.
- GAP, 0: idle cycles (en=0) inserted after every scanned bit except the last; legal range 0–15.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  word offered on load_data.
- load_ready  out  1  block can accept a word.
- load_data  in  8  word to scan.
- mux_data  out  8  drives mux inputs; bit k → input ik.
- sel  out  3  mux select.
- en  out  1  mux enable.
- f  in  1  mux output (combinational from sel/en/mux_data).
- bit_strobe  out  1  high in each cycle f is sampled.
- last  out  1  high with bit_strobe on the final channel.
- rx_data  out  8  captured bits; bit k = f sampled while sel=k.
- done  out  1  one-cycle pulse at scan end.
- mismatch  out  1  rx_data != mux_data, valid from done, held until next accept.

## Operation
- States: IDLE, SHIFT, WAIT, DONE.
- IDLE:
  - load_ready=1, en=0, sel=start index (0 if LSB_FIRST, else 7).
  - On load_valid & load_ready at an edge: mux_data←load_data, rx_data←0, mismatch←0, go to SHIFT.
- SHIFT:
  - en=1, bit_strobe=1.
  - At the edge ending the cycle: rx_data[sel]←f.
  - If the current channel is the last one (7 for LSB_FIRST, 0 otherwise): go to DONE.
  - Otherwise, if GAP=0, advance sel by ±1 and stay in SHIFT; else go to WAIT with gap counter←GAP-1.
- WAIT:
  - en=0; sel holds.
  - When the counter reaches 0: advance sel and go to SHIFT; otherwise decrement the counter.
- DONE:
  - done=1, en=0, mismatch←(rx_data != mux_data) registered at entry and held.
  - Next edge: IDLE with sel←start index.
- load_ready is 0 in all states other than IDLE; load_valid outside IDLE is ignored and has no side effects.
- mux_data is stable from accept until the next accept.
- sel arithmetic is 3-bit and never wraps within a scan; the end channel terminates the scan.

## Timing
- Reset values (any state, including mid-scan):
  - State IDLE, sel=start index, en=0, mux_data=0, rx_data=0.
  - bit_strobe=0, last=0, done=0, mismatch=0.
  - load_ready=0 while rst=1, then 1 from the first cycle after rst deasserts.
- Reset mid-scan aborts the scan with no done pulse.
- Accept at edge N → first SHIFT cycle is N+1.
- Scan length is 8 + 7·GAP cycles, followed by 1 DONE cycle; load_ready returns in the cycle after DONE.
  - GAP=0: accept at edge 0; SHIFT cycles 1–8, DONE cycle 9, load_ready=1 in cycle 10.
- Throughput, GAP=0: one word per 10 cycles (accept cycle + 8 + DONE).
- f is sampled at the rising edge that ends each SHIFT cycle, so the mux path must settle within one cycle.
- done and last never coincide: last accompanies the final SHIFT cycle, and done follows one cycle later.

## Test plan
- Reset/idle: hold rst 3 cycles → all outputs at reset values, load_ready=0; release → load_ready=1, sel=0, en=0.
- Walking scan, GAP=0, LSB_FIRST=1, ideal mux: load 8'hA5 →
  - sel 0..7 on consecutive cycles with en=1;
  - last in the sel=7 cycle;
  - done one cycle later, rx_data=8'hA5, mismatch=0.
- Reverse scan with gaps, LSB_FIRST=0, GAP=2: load 8'h3C →
  - sel 7..0, each SHIFT cycle followed by 2 cycles of en=0 (none after sel=0);
  - done at cycle 1+8+14, rx_data=8'h3C.
- Fault injection: force f=0 whenever sel=5, load 8'hFF → rx_data=8'hDF, mismatch=1, held until the next accept.
- Handshake and reset: load_valid with 8'h00 asserted mid-scan of 8'h81 → ignored, result is 8'h81. Then assert rst at the 4th SHIFT cycle of a new scan → no done pulse, IDLE next cycle, rx_data=0.

Source files
------------

// File: rtl/mux8_scan_ctrl.sv
// Scan sequencer for an 8-to-1 mux: drives a word onto the mux inputs, walks the
// select lines, captures the mux output per channel and flags any disagreement.
module mux8_scan_ctrl #(
    parameter int LSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    output logic [7:0] mux_data,
    output logic [2:0] sel,
    output logic       en,
    input  logic       f,
    output logic       bit_strobe,
    output logic       last,
    output logic [7:0] rx_data,
    output logic       done,
    output logic       mismatch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] START_SEL = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
    localparam logic [2:0] END_SEL   = (LSB_FIRST != 0) ? 3'd7 : 3'd0;
    localparam logic [3:0] GAP_LOAD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam bit         HAS_GAP   = (GAP > 0);

    state_t     state_r, state_nxt_s;
    logic [2:0] sel_r, sel_nxt_s;
    logic [3:0] cnt_r, cnt_nxt_s;
    logic [7:0] mux_data_r, mux_data_nxt_s;
    logic [7:0] rx_data_r, rx_data_nxt_s;
    logic       mismatch_r, mismatch_nxt_s;
    logic       en_r, bit_strobe_r, last_r, done_r, load_ready_r;
    logic       last_nxt_s;

    function automatic logic [2:0] step_sel(input logic [2:0] s);
        if (LSB_FIRST != 0) begin
            step_sel = s + 3'd1;
        end else begin
            step_sel = s - 3'd1;
        end
    endfunction

    // Next-state, select walk, capture and result evaluation
    always_comb begin
        state_nxt_s    = state_r;
        sel_nxt_s      = sel_r;
        cnt_nxt_s      = cnt_r;
        mux_data_nxt_s = mux_data_r;
        rx_data_nxt_s  = rx_data_r;
        mismatch_nxt_s = mismatch_r;
        case (state_r)
            IDLE: begin
                sel_nxt_s = START_SEL;
                if (load_valid && load_ready_r) begin
                    mux_data_nxt_s = load_data;
                    rx_data_nxt_s  = 8'h00;
                    mismatch_nxt_s = 1'b0;
                    state_nxt_s    = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                rx_data_nxt_s[sel_r] = f;
                if (sel_r == END_SEL) begin
                    // Compare against the word including the bit captured this edge
                    mismatch_nxt_s = (rx_data_nxt_s != mux_data_r);
                    state_nxt_s    = DONE;
                end else if (!HAS_GAP) begin
                    sel_nxt_s = step_sel(sel_r);
                end else begin
                    cnt_nxt_s   = GAP_LOAD;
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    sel_nxt_s   = step_sel(sel_r);
                    state_nxt_s = SHIFT;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            DONE: begin
                sel_nxt_s   = START_SEL;
                state_nxt_s = IDLE;
            end
            default: begin
                sel_nxt_s   = START_SEL;
                state_nxt_s = IDLE;
            end
        endcase
        last_nxt_s = (state_nxt_s == SHIFT) && (sel_nxt_s == END_SEL);
    end

    // State, datapath and registered output decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            sel_r        <= START_SEL;
            cnt_r        <= 4'd0;
            mux_data_r   <= 8'h00;
            rx_data_r    <= 8'h00;
            mismatch_r   <= 1'b0;
            en_r         <= 1'b0;
            bit_strobe_r <= 1'b0;
            last_r       <= 1'b0;
            done_r       <= 1'b0;
            load_ready_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            sel_r        <= sel_nxt_s;
            cnt_r        <= cnt_nxt_s;
            mux_data_r   <= mux_data_nxt_s;
            rx_data_r    <= rx_data_nxt_s;
            mismatch_r   <= mismatch_nxt_s;
            en_r         <= (state_nxt_s == SHIFT);
            bit_strobe_r <= (state_nxt_s == SHIFT);
            last_r       <= last_nxt_s;
            done_r       <= (state_nxt_s == DONE);
            load_ready_r <= (state_nxt_s == IDLE);
        end
    end

    assign load_ready = load_ready_r;
    assign mux_data   = mux_data_r;
    assign sel        = sel_r;
    assign en         = en_r;
    assign bit_strobe = bit_strobe_r;
    assign last       = last_r;
    assign rx_data    = rx_data_r;
    assign done       = done_r;
    assign mismatch   = mismatch_r;

endmodule
